// File: rtl/seg7_pkg.sv
// Shared constants for the 4-digit seven-segment scanner: active-low
// segment patterns in {g,f,e,d,c,b,a} order and the all-off anode word.
package seg7_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;

  localparam logic [3:0] ANODES_OFF = 4'b1111;

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD to active-low seven-segment decoder; non-BCD codes
// (10-15) render as a dash so bad upstream data is visible on the board.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_scan_4digit.sv
// Time-multiplexed driver for a 4-digit common-anode display with shadowed
// digits, guard-off cycles per slot, leading-zero blanking and decimal point.
module seg7_scan_4digit
  import seg7_pkg::*;
#(
  parameter int PRESCALE = 100000,
  parameter int GUARD    = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] bcd0,
  input  logic [3:0] bcd1,
  input  logic [3:0] bcd2,
  input  logic [3:0] bcd3,
  input  logic       load,
  input  logic       dp_en,
  input  logic [1:0] dp_pos,
  input  logic       blank_lz,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] GUARD_C  = CNT_W'(GUARD);

  logic [NUM_DIGITS-1:0][3:0] dig_q, dig_d;
  logic                       dp_en_q, dp_en_d;
  logic [1:0]                 dp_pos_q, dp_pos_d;
  logic                       blank_lz_q, blank_lz_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [1:0]                 idx_q, idx_d;
  logic [3:0]                 an_q, an_d;
  logic [6:0]                 seg_q, seg_d;
  logic                       dp_q, dp_d;

  logic [6:0]            dec_seg;
  logic [NUM_DIGITS-1:0] blank;
  logic                  zeros_above;

  seg7_decode u_decode (
    .bcd (dig_q[idx_q]),
    .seg (dec_seg)
  );

  always_comb begin
    dig_d      = dig_q;
    dp_en_d    = dp_en_q;
    dp_pos_d   = dp_pos_q;
    blank_lz_d = blank_lz_q;
    if (load) begin
      dig_d      = {bcd3, bcd2, bcd1, bcd0};
      dp_en_d    = dp_en;
      dp_pos_d   = dp_pos;
      blank_lz_d = blank_lz;
    end
  end

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    idx_d = idx_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
    end
  end

  // Walk from the most significant digit down so each digit knows whether
  // it and everything to its left is zero; the DP position shields digits.
  always_comb begin
    blank       = '0;
    zeros_above = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zeros_above = zeros_above & (dig_q[k] == 4'd0);
      blank[k]    = (k != 0) && blank_lz_q && zeros_above &&
                    !(dp_en_q && (dp_pos_q >= 2'(k)));
    end
  end

  always_comb begin
    an_d  = ANODES_OFF;
    seg_d = SEG_OFF;
    dp_d  = 1'b1;
    if (cnt_q >= GUARD_C) begin
      an_d = ~(4'b0001 << idx_q);
      if (!blank[idx_q]) begin
        seg_d = dec_seg;
        dp_d  = ~(dp_en_q && (dp_pos_q == idx_q));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dig_q      <= '0;
      dp_en_q    <= 1'b0;
      dp_pos_q   <= 2'd0;
      blank_lz_q <= 1'b0;
      cnt_q      <= '0;
      idx_q      <= 2'd0;
      an_q       <= ANODES_OFF;
      seg_q      <= SEG_OFF;
      dp_q       <= 1'b1;
    end else begin
      dig_q      <= dig_d;
      dp_en_q    <= dp_en_d;
      dp_pos_q   <= dp_pos_d;
      blank_lz_q <= blank_lz_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_seg7_scan_4digit.sv
// Directed bench for seg7_scan_4digit with PRESCALE=8, GUARD=2; expected
// pin values come from hand-written segment codes and the slot timing.
module tb_seg7_scan_4digit;

  localparam logic [6:0] S0   = 7'b1000000;
  localparam logic [6:0] S1   = 7'b1111001;
  localparam logic [6:0] S2   = 7'b0100100;
  localparam logic [6:0] S3   = 7'b0110000;
  localparam logic [6:0] S4   = 7'b0011001;
  localparam logic [6:0] S5   = 7'b0010010;
  localparam logic [6:0] S7   = 7'b1111000;
  localparam logic [6:0] S9   = 7'b0010000;
  localparam logic [6:0] DASH = 7'b0111111;
  localparam logic [6:0] OFF  = 7'b1111111;
  localparam logic [11:0] ALL_OFF = {4'b1111, 7'b1111111, 1'b1};

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] bcd0, bcd1, bcd2, bcd3;
  logic       load, dp_en, blank_lz;
  logic [1:0] dp_pos;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int checks   = 0;
  int failures = 0;
  int ecnt     = 0;

  seg7_scan_4digit #(.PRESCALE(8), .GUARD(2)) dut (
    .clk(clk), .rst_n(rst_n), .bcd0(bcd0), .bcd1(bcd1), .bcd2(bcd2),
    .bcd3(bcd3), .load(load), .dp_en(dp_en), .dp_pos(dp_pos),
    .blank_lz(blank_lz), .an(an), .seg(seg), .dp(dp)
  );

  // clock / reset-relative edge counter
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ecnt <= 0;
    else        ecnt <= ecnt + 1;
  end

  // Expected pins for output cycle p after reset release (p = ecnt-1 at negedge).
  function automatic logic [11:0] exp_out(input int p, input logic [3:0][6:0] es,
                                          input logic [3:0] edp);
    int c, s;
    c = p % 8;
    s = (p / 8) % 4;
    if (c < 2) return ALL_OFF;
    return {~(4'b0001 << s), es[s], edp[s]};
  endfunction

  // driver
  task automatic drive_load(input logic [3:0] b3, input logic [3:0] b2,
                            input logic [3:0] b1, input logic [3:0] b0,
                            input logic den, input logic [1:0] dpos, input logic blz);
    @(negedge clk);
    bcd3 = b3; bcd2 = b2; bcd1 = b1; bcd0 = b0;
    dp_en = den; dp_pos = dpos; blank_lz = blz;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic test_reset();
    logic [11:0] e;
    rst_n = 1'b1; load = 1'b0; dp_en = 1'b0; dp_pos = 2'd0; blank_lz = 1'b0;
    bcd0 = 4'd0; bcd1 = 4'd0; bcd2 = 4'd0; bcd3 = 4'd0;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({an, seg, dp} !== ALL_OFF) begin
      failures++;
      $display("FAIL reset_async: got=%b exp=%b", {an, seg, dp}, ALL_OFF);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({an, seg, dp} !== ALL_OFF) begin
        failures++;
        $display("FAIL reset_hold cyc=%0d: got=%b exp=%b", i, {an, seg, dp}, ALL_OFF);
      end
    end
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      e = exp_out(ecnt - 1, {S0, S0, S0, S0}, 4'b1111);
      checks++;
      if ({an, seg, dp} !== e) begin
        failures++;
        $display("FAIL reset_release p=%0d: got=%b exp=%b", ecnt - 1, {an, seg, dp}, e);
      end
    end
  endtask

  task automatic test_scan();
    logic [11:0] e;
    drive_load(4'd1, 4'd2, 4'd3, 4'd4, 1'b0, 2'd0, 1'b0);
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      e = exp_out(ecnt - 1, {S1, S2, S3, S4}, 4'b1111);
      checks++;
      if ({an, seg, dp} !== e) begin
        failures++;
        $display("FAIL scan_1234 p=%0d: got=%b exp=%b", ecnt - 1, {an, seg, dp}, e);
      end
    end
  endtask

  task automatic test_blank();
    logic [11:0] e;
    drive_load(4'd0, 4'd0, 4'd4, 4'd7, 1'b0, 2'd0, 1'b1);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      e = exp_out(ecnt - 1, {OFF, OFF, S4, S7}, 4'b1111);
      checks++;
      if ({an, seg, dp} !== e) begin
        failures++;
        $display("FAIL blank_0047 p=%0d: got=%b exp=%b", ecnt - 1, {an, seg, dp}, e);
      end
    end
    drive_load(4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 2'd0, 1'b1);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      e = exp_out(ecnt - 1, {OFF, OFF, OFF, S0}, 4'b1111);
      checks++;
      if ({an, seg, dp} !== e) begin
        failures++;
        $display("FAIL blank_0000 p=%0d: got=%b exp=%b", ecnt - 1, {an, seg, dp}, e);
      end
    end
  endtask

  task automatic test_dp();
    logic [11:0] e;
    drive_load(4'd0, 4'd0, 4'd0, 4'd5, 1'b1, 2'd2, 1'b1);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      e = exp_out(ecnt - 1, {OFF, S0, S0, S5}, 4'b1011);
      checks++;
      if ({an, seg, dp} !== e) begin
        failures++;
        $display("FAIL dp_pos2 p=%0d: got=%b exp=%b", ecnt - 1, {an, seg, dp}, e);
      end
    end
    drive_load(4'd0, 4'd0, 4'd0, 4'd0, 1'b1, 2'd3, 1'b1);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      e = exp_out(ecnt - 1, {S0, S0, S0, S0}, 4'b0111);
      checks++;
      if ({an, seg, dp} !== e) begin
        failures++;
        $display("FAIL dp_pos3 p=%0d: got=%b exp=%b", ecnt - 1, {an, seg, dp}, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] e;
    bit found;
    drive_load(4'hF, 4'd0, 4'd0, 4'hC, 1'b0, 2'd0, 1'b0);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      e = exp_out(ecnt - 1, {DASH, S0, S0, DASH}, 4'b1111);
      checks++;
      if ({an, seg, dp} !== e) begin
        failures++;
        $display("FAIL dash p=%0d: got=%b exp=%b", ecnt - 1, {an, seg, dp}, e);
      end
    end
    // Position so the load edge is the one where cnt=7 in slot 0.
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (ecnt % 32 == 7) found = 1'b1;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL b2b_align: got=0 exp=1");
    end
    bcd1 = 4'd9;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    e = {4'b1110, DASH, 1'b1};
    checks++;
    if ({an, seg, dp} !== e) begin
      failures++;
      $display("FAIL b2b_last_old p=%0d: got=%b exp=%b", ecnt - 1, {an, seg, dp}, e);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      e = exp_out(ecnt - 1, {DASH, S0, S9, DASH}, 4'b1111);
      checks++;
      if ({an, seg, dp} !== e) begin
        failures++;
        $display("FAIL b2b_new p=%0d: got=%b exp=%b", ecnt - 1, {an, seg, dp}, e);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [11:0] e;
    bit found;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (ecnt % 32 == 21) found = 1'b1;
    end
    e = exp_out(ecnt - 1, {DASH, S0, S9, DASH}, 4'b1111);
    checks++;
    if (!found || {an, seg, dp} !== e) begin
      failures++;
      $display("FAIL midslot_lit found=%0d: got=%b exp=%b", found, {an, seg, dp}, e);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({an, seg, dp} !== ALL_OFF) begin
      failures++;
      $display("FAIL midslot_async_off: got=%b exp=%b", {an, seg, dp}, ALL_OFF);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      e = exp_out(ecnt - 1, {S0, S0, S0, S0}, 4'b1111);
      checks++;
      if ({an, seg, dp} !== e) begin
        failures++;
        $display("FAIL restart p=%0d: got=%b exp=%b", ecnt - 1, {an, seg, dp}, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_blank();
    test_dp();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
